// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
// branch_pred_unit : EX-stage branch resolver with an IF-stage bimodal BHT.
// Optional feature macro BRU_STATS_EN adds branch/miss counters.  Rev 1.0
// ============================================================================
module branch_pred_unit #(
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [2:0]        res_branch,
  input  logic              res_less,
  input  logic              res_zero,
  input  logic              res_pred_taken,
  output logic              pc_a_src,
  output logic              pc_b_src,
  output logic              mispredict
`ifdef BRU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_misses
`endif
);

  localparam int               c_entries  = 2**IDX_W;
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_init = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0] r_bht [c_entries];
  logic             r_mispredict;
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_taken;
  logic             w_cond;
  logic             w_miss;
  logic             unused_pc_bits;

  assign w_pred_idx = pred_pc[IDX_W+1:2];
  assign w_res_idx  = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            res_pc[31:IDX_W+2], res_pc[1:0]};

  // Lookup reads the array before any same-cycle write lands.
  assign pred_taken = r_bht[w_pred_idx][CNT_W-1];

  always_comb begin
    w_taken = 1'b0;
    case (res_branch[1:0])
      2'b00:   w_taken = res_zero;
      2'b01:   w_taken = ~res_zero;
      2'b10:   w_taken = res_less;
      2'b11:   w_taken = ~res_less;
      default: w_taken = 1'b0;
    endcase
  end

  // Selects follow res_branch even when res_valid is low.
  always_comb begin
    pc_a_src = 1'b0;
    pc_b_src = 1'b0;
    case (res_branch)
      3'b001: pc_a_src = 1'b1;
      3'b010: begin
        pc_a_src = 1'b1;
        pc_b_src = 1'b1;
      end
      3'b100, 3'b101, 3'b110, 3'b111: pc_a_src = w_taken;
      default: begin
        pc_a_src = 1'b0;
        pc_b_src = 1'b0;
      end
    endcase
  end

  assign w_cond = res_valid & res_branch[2];
  assign w_miss = w_cond & (w_taken != res_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_entries; i++) begin
        r_bht[i] <= c_cnt_init;
      end
    end else if (w_cond) begin
      if (w_taken) begin
        if (r_bht[w_res_idx] != c_cnt_max) r_bht[w_res_idx] <= r_bht[w_res_idx] + c_cnt_one;
      end else begin
        if (r_bht[w_res_idx] != '0) r_bht[w_res_idx] <= r_bht[w_res_idx] - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mispredict <= 1'b0;
    else        r_mispredict <= w_miss;
  end

  assign mispredict = r_mispredict;

`ifdef BRU_STATS_EN
  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches <= '0;
      r_stat_misses   <= '0;
    end else begin
      if (w_cond) r_stat_branches <= r_stat_branches + STAT_W'(1);
      if (w_miss) r_stat_misses   <= r_stat_misses + STAT_W'(1);
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_misses   = r_stat_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_pred_unit : randomized + directed bench with a counter-array model.
// Honours BRU_STATS_EN for the stat ports.  Rev 1.0
// ============================================================================
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pred_pc = 32'h8000_0000;
  logic        pred_taken, pred_taken3;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'h8000_0000;
  logic [2:0]  res_branch = 3'b000;
  logic        res_less = 1'b0;
  logic        res_zero = 1'b0;
  logic        res_pred_taken = 1'b0;
  logic        pc_a_src, pc_b_src, mispredict;
  logic        pc_a_src3, pc_b_src3, mispredict3;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_misses, stat_branches3, stat_misses3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integer counters per BHT slot, CNT_W=2 (0..3).
  int          m_cnt [64];
  bit          m_mis;
  logic [31:0] m_branches, m_misses;

  always #5 clk = ~clk;

  branch_pred_unit #(.IDX_W(6), .CNT_W(2), .STAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_branch(res_branch),
    .res_less(res_less), .res_zero(res_zero), .res_pred_taken(res_pred_taken),
    .pc_a_src(pc_a_src), .pc_b_src(pc_b_src), .mispredict(mispredict)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_misses(stat_misses)
`endif
  );

  branch_pred_unit #(.IDX_W(6), .CNT_W(3), .STAT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken3),
    .res_valid(res_valid), .res_pc(res_pc), .res_branch(res_branch),
    .res_less(res_less), .res_zero(res_zero), .res_pred_taken(res_pred_taken),
    .pc_a_src(pc_a_src3), .pc_b_src(pc_b_src3), .mispredict(mispredict3)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches3), .stat_misses(stat_misses3)
`endif
  );

  function automatic bit exp_taken(input logic [2:0] br, input logic less, input logic zero);
    case (br)
      3'b100:  return zero;    // beq
      3'b101:  return !zero;   // bne
      3'b110:  return less;    // blt
      3'b111:  return !less;   // bge
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_sel(input logic [2:0] br, input logic less, input logic zero);
    if (br[2]) return exp_taken(br, less, zero) ? 2'b10 : 2'b00;
    if (br == 3'b001) return 2'b10;
    if (br == 3'b010) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_cnt[int'(pc[7:2])] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_mis = 1'b0;
    m_branches = '0;
    m_misses = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] br,
                       input logic less, input logic zero, input logic rpt);
    res_valid = v; res_pc = pc; res_branch = br;
    res_less = less; res_zero = zero; res_pred_taken = rpt;
  endtask

  // One clock: model captures pre-edge inputs, DUT outputs are read 1 ns after the edge.
  task automatic tick();
    bit cond, tk, miss;
    int idx;
    cond = res_valid && res_branch[2];
    tk   = exp_taken(res_branch, res_less, res_zero);
    miss = cond && (tk != res_pred_taken);
    idx  = int'(res_pc[7:2]);
    @(posedge clk);
    if (rst_n) begin
      if (cond) begin
        if (tk) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        else    m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
        m_branches = m_branches + 1;
      end
      if (miss) m_misses = m_misses + 1;
      m_mis = miss;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pred_pc = 32'h8000_0010;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred_0x80000010 got=%b exp=0", pred_taken);
    end
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL reset_mispredict got=%b exp=0", mispredict);
    end
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_misses);
    end
`endif
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'h8000_0000 | (32'(i) << 2);
      #1;
      n_checks++;
      if (pred_taken !== 1'b0 || pred_taken3 !== 1'b0) begin
        n_fail++; $display("FAIL reset_pred_idx%0d got=%b/%b exp=0/0", i, pred_taken, pred_taken3);
      end
    end
  endtask

  task automatic test_nonconditional();
    logic [1:0] sel;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 32'h8000_0020, 3'(b), 1'($urandom), 1'($urandom), 1'b1);
      pred_pc = 32'h8000_0020;
      #1;
      sel = exp_sel(3'(b), res_less, res_zero);
      n_checks++;
      if ({pc_a_src, pc_b_src} !== sel) begin
        n_fail++; $display("FAIL sel_br%0d got=%b%b exp=%b", b, pc_a_src, pc_b_src, sel);
      end
      tick();
      n_checks++;
      if (mispredict !== 1'b0 || pred_taken !== m_pred(pred_pc)) begin
        n_fail++; $display("FAIL nocond_br%0d mis=%b pred=%b exp=0/%b", b, mispredict, pred_taken, m_pred(pred_pc));
      end
    end
    // Conditional branch with res_valid low: selects still decode, nothing trains.
    drive(1'b0, 32'h8000_0020, 3'b100, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({pc_a_src, pc_b_src} !== 2'b10) begin
      n_fail++; $display("FAIL sel_invalid_beq got=%b%b exp=10", pc_a_src, pc_b_src);
    end
    tick();
    tick();
    n_checks++;
    if (mispredict !== 1'b0 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL invalid_no_train mis=%b pred=%b exp=0/0", mispredict, pred_taken);
    end
    drive(1'b0, 32'h8000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_beq_training();
    pred_pc = 32'h8000_0010;
    drive(1'b1, 32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (mispredict !== 1'b1 || pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL beq1 mis=%b pred=%b exp=1/1", mispredict, pred_taken);
    end
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_misses !== 32'd1 || stat_branches !== 32'd1) begin
      n_fail++; $display("FAIL beq1_stats got=%0d/%0d exp=1/1", stat_branches, stat_misses);
    end
`endif
    drive(1'b1, 32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (mispredict !== 1'b0 || m_cnt[4] != 3) begin
      n_fail++; $display("FAIL beq2 mis=%b model_cnt=%0d exp=0/3", mispredict, m_cnt[4]);
    end
    tick();
    // A single not-taken must leave it still predicting taken if it saturated at 3.
    drive(1'b1, 32'h8000_0010, 3'b100, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (mispredict !== 1'b1 || pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL beq_saturate mis=%b pred=%b exp=1/1", mispredict, pred_taken);
    end
    drive(1'b0, 32'h8000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL mis_clear got=%b exp=0", mispredict);
    end
  endtask

  task automatic test_cond_selects();
    drive(1'b1, 32'h8000_0040, 3'b110, 1'b1, 1'b0, 1'b0);
    pred_pc = 32'h8000_0040;
    #1;
    n_checks++;
    if ({pc_a_src, pc_b_src} !== 2'b10) begin
      n_fail++; $display("FAIL sel_blt got=%b%b exp=10", pc_a_src, pc_b_src);
    end
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_old got=%b exp=0", pred_taken);
    end
    tick();
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_new got=%b exp=1", pred_taken);
    end
    drive(1'b0, 32'h8000_0040, 3'b111, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_a_src, pc_b_src} !== 2'b00) begin
      n_fail++; $display("FAIL sel_bge got=%b%b exp=00", pc_a_src, pc_b_src);
    end
    drive(1'b0, 32'h8000_0040, 3'b101, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({pc_a_src, pc_b_src} !== 2'b10) begin
      n_fail++; $display("FAIL sel_bne got=%b%b exp=10", pc_a_src, pc_b_src);
    end
    drive(1'b0, 32'h8000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_aliasing();
    pred_pc = 32'h8000_0100;
    repeat (2) begin
      drive(1'b1, 32'h8000_0000, 3'b100, 1'b0, 1'b1, 1'b0);
      tick();
    end
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL alias_shared got=%b exp=1", pred_taken);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k[0] ? 32'h8000_0100 : 32'h8000_0000, 3'b101, 1'b0, 1'b1, 1'b0);
      tick();
    end
    n_checks++;
    if (pred_taken !== 1'b0 || m_cnt[0] != 0) begin
      n_fail++; $display("FAIL alias_floor pred=%b model=%0d exp=0/0", pred_taken, m_cnt[0]);
    end
    // One taken from the floor gives 01, still not-taken.
    drive(1'b1, 32'h8000_0000, 3'b100, 1'b0, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL alias_from_zero got=%b exp=0", pred_taken);
    end
    drive(1'b0, 32'h8000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] sel;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0),
            32'h8000_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2),
            3'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      res_pred_taken = ($urandom_range(0, 3) != 0) ? m_pred(res_pc) : 1'($urandom);
      pred_pc = $urandom_range(0, 1) ? res_pc
              : (32'h8000_0000 | (32'($urandom_range(0, 7)) << 2));
      #1;
      sel = exp_sel(res_branch, res_less, res_zero);
      n_checks++;
      if ({pc_a_src, pc_b_src} !== sel || pred_taken !== m_pred(pred_pc)) begin
        n_fail++;
        $display("FAIL rand_comb n=%0d sel=%b%b exp=%b pred=%b exp=%b", n, pc_a_src, pc_b_src, sel, pred_taken, m_pred(pred_pc));
      end
      tick();
      n_checks++;
      if (mispredict !== m_mis) begin
        n_fail++; $display("FAIL rand_mis n=%0d got=%b exp=%b", n, mispredict, m_mis);
      end
`ifdef BRU_STATS_EN
      n_checks++;
      if (stat_branches !== m_branches || stat_misses !== m_misses) begin
        n_fail++;
        $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stat_branches, stat_misses, m_branches, m_misses);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    pred_pc = 32'h8000_0030;
    repeat (2) begin
      drive(1'b1, 32'h8000_0030, 3'b100, 1'b0, 1'b1, 1'b0);
      tick();
    end
    n_checks++;
    if (mispredict !== m_mis || pred_taken !== m_pred(pred_pc)) begin
      n_fail++; $display("FAIL pre_reset mis=%b pred=%b exp=%b/%b", mispredict, pred_taken, m_mis, m_pred(pred_pc));
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (mispredict !== 1'b0 || pred_taken !== 1'b0 || pred_taken3 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset mis=%b pred=%b pred3=%b exp=0/0/0", mispredict, pred_taken, pred_taken3);
    end
`ifdef BRU_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_misses);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 32'h8000_0030, 3'b100, 1'b0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_train pred=%b mis=%b exp=1/0", pred_taken, mispredict);
    end
    drive(1'b0, 32'h8000_0000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nonconditional();
    test_beq_training();
    test_cond_selects();
    test_aliasing();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
